// File: rtl/flag_pkg.sv
// Shared opcodes, flag bit indices, branch condition codes and controller states
// for the status-flag sequencing controller.
package flag_pkg;

    localparam logic [4:0] OP_ADD  = 5'h00;
    localparam logic [4:0] OP_SUB  = 5'h01;
    localparam logic [4:0] OP_ADDI = 5'h02;
    localparam logic [4:0] OP_AND  = 5'h03;
    localparam logic [4:0] OP_OR   = 5'h04;
    localparam logic [4:0] OP_XOR  = 5'h05;
    localparam logic [4:0] OP_NOT  = 5'h06;
    localparam logic [4:0] OP_INV  = 5'h07;
    localparam logic [4:0] OP_ROR  = 5'h08;
    localparam logic [4:0] OP_ROL  = 5'h09;
    localparam logic [4:0] OP_SHR  = 5'h0A;
    localparam logic [4:0] OP_SHL  = 5'h0B;
    localparam logic [4:0] OP_LDIF = 5'h19;
    localparam logic [4:0] OP_MOVF = 5'h1A;

    localparam int unsigned FLG_Z = 0;
    localparam int unsigned FLG_C = 1;
    localparam int unsigned FLG_N = 2;
    localparam int unsigned FLG_O = 3;

    typedef enum logic [2:0] {
        CC_Z  = 3'd0,
        CC_NZ = 3'd1,
        CC_C  = 3'd2,
        CC_NC = 3'd3,
        CC_N  = 3'd4,
        CC_NN = 3'd5,
        CC_O  = 3'd6,
        CC_AL = 3'd7
    } cond_e;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        COMMIT
    } state_e;

    function automatic logic cond_eval(input logic [3:0] f, input logic [2:0] code);
        logic r;
        case (cond_e'(code))
            CC_Z:    r = f[FLG_Z];
            CC_NZ:   r = ~f[FLG_Z];
            CC_C:    r = f[FLG_C];
            CC_NC:   r = ~f[FLG_C];
            CC_N:    r = f[FLG_N];
            CC_NN:   r = ~f[FLG_N];
            CC_O:    r = f[FLG_O];
            default: r = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/flag_mask_dec.sv
// Opcode decoder: which flag bits an instruction may update and whether it must
// wait for an ALU flag result.
module flag_mask_dec
    import flag_pkg::*;
#(
    parameter int unsigned NFLAGS = 8
) (
    input  logic [4:0]        op_i,
    input  logic [2:0]        sel_i,
    input  logic              val_i,
    output logic [NFLAGS-1:0] mask_o,
    output logic              needs_alu_o,
    output logic              is_ldif_o
);

    always_comb begin
        mask_o      = '0;
        needs_alu_o = 1'b0;
        is_ldif_o   = 1'b0;
        case (op_i)
            OP_ADD, OP_SUB, OP_ADDI: begin
                mask_o      = NFLAGS'(8'h0F);
                needs_alu_o = 1'b1;
            end
            OP_AND, OP_OR, OP_XOR, OP_NOT, OP_INV: begin
                mask_o      = NFLAGS'(8'h05);
                needs_alu_o = 1'b1;
            end
            OP_ROR, OP_ROL, OP_SHR, OP_SHL: begin
                mask_o      = NFLAGS'(8'h07);
                needs_alu_o = 1'b1;
            end
            OP_LDIF: begin
                // Selector 7 is a legal no-op that still goes through COMMIT.
                is_ldif_o = 1'b1;
                if (sel_i != 3'd7) begin
                    mask_o = NFLAGS'(1) << sel_i;
                end
            end
            OP_MOVF: begin
                if (!val_i) begin
                    mask_o      = '1;
                    needs_alu_o = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/flag_ctrl.sv
// Status-flag sequencing controller with masked commits and a stall-aware branch
// condition port. Define FLAG_SAVE_EN to add the save/restore shadow register.
module flag_ctrl
    import flag_pkg::*;
#(
    parameter int unsigned NFLAGS      = 8,
    parameter int unsigned ALU_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ins_valid,
    output logic              ins_ready,
    input  logic [4:0]        ins_op,
    input  logic [2:0]        ins_sel,
    input  logic              ins_val,
    input  logic              alu_valid,
    input  logic [NFLAGS-1:0] alu_flags,
    input  logic              cond_valid,
    output logic              cond_ready,
    input  logic [2:0]        cond_code,
    output logic              cond_true,
    output logic              cond_done,
`ifdef FLAG_SAVE_EN
    input  logic              save_req,
    input  logic              restore_req,
`endif
    output logic [NFLAGS-1:0] flags,
    output logic              commit,
    output logic              timeout_err
);

    localparam int unsigned CNT_W = $clog2(ALU_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ALU_TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [NFLAGS-1:0] mask_q, mask_d;
    logic [NFLAGS-1:0] src_q, src_d;
    logic [NFLAGS-1:0] flags_q, flags_d;
    logic              commit_q, commit_d;
    logic              cond_true_q, cond_true_d;
    logic              cond_done_q, cond_done_d;
    logic              timeout_err_q, timeout_err_d;
`ifdef FLAG_SAVE_EN
    logic [NFLAGS-1:0] shadow_q, shadow_d;
`endif

    logic [NFLAGS-1:0] dec_mask;
    logic              dec_needs_alu;
    logic              dec_is_ldif;
    logic              hold;

    flag_mask_dec #(
        .NFLAGS(NFLAGS)
    ) u_dec (
        .op_i       (ins_op),
        .sel_i      (ins_sel),
        .val_i      (ins_val),
        .mask_o     (dec_mask),
        .needs_alu_o(dec_needs_alu),
        .is_ldif_o  (dec_is_ldif)
    );

    always_comb begin
        hold = 1'b0;
`ifdef FLAG_SAVE_EN
        hold = save_req | restore_req;
`endif
        ins_ready  = (state_q == IDLE) && !hold;
        // Instructions take priority over queries; a transfer this cycle blocks the query.
        cond_ready = rst_n && (state_q == IDLE) && !hold && !ins_valid;

        state_d       = state_q;
        cnt_d         = cnt_q;
        mask_d        = mask_q;
        src_d         = src_q;
        flags_d       = flags_q;
        commit_d      = 1'b0;
        cond_true_d   = cond_true_q;
        cond_done_d   = 1'b0;
        timeout_err_d = timeout_err_q;
`ifdef FLAG_SAVE_EN
        shadow_d      = shadow_q;
`endif

        case (state_q)
            IDLE: begin
`ifdef FLAG_SAVE_EN
                if (restore_req) begin
                    flags_d  = shadow_q;
                    commit_d = 1'b1;
                end else if (save_req) begin
                    shadow_d = flags_q;
                end
`endif
                if (ins_valid && ins_ready) begin
                    mask_d = dec_mask;
                    src_d  = {NFLAGS{ins_val}};
                    if (dec_is_ldif) begin
                        state_d = COMMIT;
                    end else if (dec_needs_alu) begin
                        state_d = WAIT;
                        cnt_d   = '0;
                    end
                end
            end
            WAIT: begin
                if (alu_valid) begin
                    src_d   = alu_flags;
                    state_d = COMMIT;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_err_d = 1'b1;
                    state_d       = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            COMMIT: begin
                flags_d  = (flags_q & ~mask_q) | (src_q & mask_q);
                commit_d = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (cond_valid && cond_ready) begin
            cond_true_d = cond_eval(flags_q[3:0], cond_code);
            cond_done_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            mask_q        <= '0;
            src_q         <= '0;
            flags_q       <= '0;
            commit_q      <= 1'b0;
            cond_true_q   <= 1'b0;
            cond_done_q   <= 1'b0;
            timeout_err_q <= 1'b0;
`ifdef FLAG_SAVE_EN
            shadow_q      <= '0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            mask_q        <= mask_d;
            src_q         <= src_d;
            flags_q       <= flags_d;
            commit_q      <= commit_d;
            cond_true_q   <= cond_true_d;
            cond_done_q   <= cond_done_d;
            timeout_err_q <= timeout_err_d;
`ifdef FLAG_SAVE_EN
            shadow_q      <= shadow_d;
`endif
        end
    end

    assign flags       = flags_q;
    assign commit      = commit_q;
    assign cond_true   = cond_true_q;
    assign cond_done   = cond_done_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_flag_ctrl.sv
// Randomized scoreboard bench for flag_ctrl: expected commits and condition results are
// queued at issue time and checked by an independent monitor.
module tb_flag_ctrl;

    localparam int NF  = 8;
    localparam int TMO = 15;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ins_valid = 1'b0;
    logic          ins_ready;
    logic [4:0]    ins_op = '0;
    logic [2:0]    ins_sel = '0;
    logic          ins_val = 1'b0;
    logic          alu_valid = 1'b0;
    logic [NF-1:0] alu_flags = '0;
    logic          cond_valid = 1'b0;
    logic          cond_ready;
    logic [2:0]    cond_code = '0;
    logic          cond_true;
    logic          cond_done;
    logic [NF-1:0] flags;
    logic          commit;
    logic          timeout_err;

    always #5 clk = ~clk;

    flag_ctrl #(
        .NFLAGS     (NF),
        .ALU_TIMEOUT(TMO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ins_valid  (ins_valid),
        .ins_ready  (ins_ready),
        .ins_op     (ins_op),
        .ins_sel    (ins_sel),
        .ins_val    (ins_val),
        .alu_valid  (alu_valid),
        .alu_flags  (alu_flags),
        .cond_valid (cond_valid),
        .cond_ready (cond_ready),
        .cond_code  (cond_code),
        .cond_true  (cond_true),
        .cond_done  (cond_done),
`ifdef FLAG_SAVE_EN
        .save_req   (1'b0),
        .restore_req(1'b0),
`endif
        .flags      (flags),
        .commit     (commit),
        .timeout_err(timeout_err)
    );

    int         checks = 0;
    int         errors = 0;
    logic [7:0] model_flags = '0;
    logic       model_to = 1'b0;
    logic [7:0] exp_commit[$];
    logic       exp_cond[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Which flag bits each opcode class may write.
    function automatic logic [7:0] ref_mask(input logic [4:0] op, input logic [2:0] sel,
                                            input logic v);
        if (op <= 5'd2) return 8'h0F;
        if (op <= 5'd7) return 8'h05;
        if (op <= 5'd11) return 8'h07;
        if (op == 5'd25) return (sel == 3'd7) ? 8'h00 : (8'd1 << sel);
        if (op == 5'd26) return v ? 8'h00 : 8'hFF;
        return 8'h00;
    endfunction

    // Condition pairs share a flag (Z,C,N,O in bits 0..3); the odd code is the inverse.
    function automatic logic ref_cond(input logic [7:0] f, input logic [2:0] code);
        if (code == 3'd7) return 1'b1;
        return f[code[2:1]] ^ code[0];
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (commit) begin
                if (exp_commit.size() == 0) chk("unexpected_commit", 1, 0);
                else chk("commit_flags", int'(flags), int'(exp_commit.pop_front()));
            end
            if (cond_done) begin
                if (exp_cond.size() == 0) chk("unexpected_cond_done", 1, 0);
                else chk("cond_true", int'(cond_true), int'(exp_cond.pop_front()));
            end
        end
    end

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
    task automatic do_ins(input logic [4:0] op, input logic [2:0] sel, input logic v,
                          input int dly, input logic [7:0] af, input logic hold_cond);
        logic [7:0] m;
        logic       is_ldif;
        logic       needs_alu;
        int         low;
        int         exp_low;
        logic       done_ok;
        m         = ref_mask(op, sel, v);
        is_ldif   = (op == 5'd25);
        needs_alu = (op <= 5'd11) || (op == 5'd26 && !v);
        ins_valid = 1'b1;
        ins_op    = op;
        ins_sel   = sel;
        ins_val   = v;
        alu_valid = ($urandom_range(0, 3) == 0);
        alu_flags = 8'($urandom);
        if (hold_cond) begin
            cond_valid = 1'b1;
            cond_code  = 3'd0;
            #1 chk("cond_ready_prio", int'(cond_ready), 0);
        end
        if (is_ldif) begin
            model_flags = (model_flags & ~m) | ({8{v}} & m);
            exp_commit.push_back(model_flags);
        end
        exp_low = is_ldif ? 1 : (needs_alu ? ((dly < TMO) ? dly + 2 : TMO) : 0);
        low     = 0;
        done_ok = 1'b0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            ins_valid = 1'b0;
            alu_valid = 1'b0;
            alu_flags = 8'($urandom);
            if (ins_ready) begin
                done_ok = 1'b1;
                break;
            end
            low++;
            if (hold_cond) begin
                #1 chk("cond_ready_busy", int'(cond_ready), 0);
            end
            if (needs_alu && cyc == dly + 1) begin
                alu_valid   = 1'b1;
                alu_flags   = af;
                model_flags = (model_flags & ~m) | (af & m);
                exp_commit.push_back(model_flags);
            end
        end
        if (!done_ok) chk("ready_return_bound", 0, 1);
        if (needs_alu && dly >= TMO) model_to = 1'b1;
        chk("ready_low_cycles", low, exp_low);
        chk("timeout_err", int'(timeout_err), int'(model_to));
        chk("flags", int'(flags), int'(model_flags));
        if (hold_cond) begin
            #1 chk("cond_ready_idle", int'(cond_ready), 1);
            exp_cond.push_back(ref_cond(model_flags, 3'd0));
            @(negedge clk);
            cond_valid = 1'b0;
        end
    endtask

    task automatic do_cond(input logic [2:0] code);
        cond_valid = 1'b1;
        cond_code  = code;
        #1 chk("cond_ready", int'(cond_ready), 1);
        exp_cond.push_back(ref_cond(model_flags, code));
        @(negedge clk);
        cond_valid = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] op;
        repeat (2) @(negedge clk);
        chk("reset_flags", int'(flags), 0);
        chk("reset_ins_ready", int'(ins_ready), 1);
        chk("reset_cond_ready", int'(cond_ready), 0);
        chk("reset_commit", int'(commit), 0);
        chk("reset_cond_done", int'(cond_done), 0);
        chk("reset_cond_true", int'(cond_true), 0);
        chk("reset_timeout_err", int'(timeout_err), 0);
        rst_n = 1'b1;
        @(negedge clk);

        do_ins(5'h00, 3'd0, 1'b0, 3, 8'hFF, 1'b0);
        do_ins(5'h03, 3'd0, 1'b0, 1, 8'h00, 1'b0);
        do_ins(5'h19, 3'd5, 1'b1, 0, 8'h00, 1'b0);
        do_ins(5'h19, 3'd7, 1'b1, 0, 8'h00, 1'b0);
        do_ins(5'h1A, 3'd0, 1'b0, 2, 8'hA5, 1'b0);
        do_ins(5'h1A, 3'd0, 1'b1, 0, 8'h3C, 1'b0);
        do_ins(5'h00, 3'd0, 1'b0, 99, 8'h00, 1'b0);
        do_ins(5'h19, 3'd0, 1'b1, 0, 8'h00, 1'b0);
        do_ins(5'h01, 3'd0, 1'b0, 4, 8'($urandom), 1'b1);
        do_ins(5'h00, 3'd0, 1'b0, 14, 8'h0E, 1'b0);
        for (int c = 0; c < 8; c++) do_cond(3'(c));

        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                do_cond(3'($urandom_range(0, 7)));
            end else begin
                case ($urandom_range(0, 3))
                    0, 1:    op = 5'($urandom_range(0, 11));
                    2:       op = ($urandom_range(0, 1) == 0) ? 5'h19 : 5'h1A;
                    default: op = 5'($urandom_range(0, 31));
                endcase
                do_ins(op, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                       $urandom_range(0, 16), 8'($urandom), $urandom_range(0, 7) == 0);
            end
        end

        // Reset while waiting on the ALU must discard the instruction entirely.
        ins_valid = 1'b1;
        ins_op    = 5'h00;
        @(negedge clk);
        ins_valid = 1'b0;
        rst_n     = 1'b0;
        alu_valid = 1'b1;
        alu_flags = 8'hFF;
        @(negedge clk);
        rst_n       = 1'b1;
        alu_valid   = 1'b0;
        model_flags = '0;
        model_to    = 1'b0;
        chk("midop_reset_flags", int'(flags), 0);
        chk("midop_reset_timeout_err", int'(timeout_err), 0);
        chk("midop_reset_ins_ready", int'(ins_ready), 1);
        repeat (3) @(negedge clk);
        chk("midop_reset_flags_hold", int'(flags), 0);

        chk("commit_queue_drained", exp_commit.size(), 0);
        chk("cond_queue_drained", exp_cond.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
